rs_bm_solver: RTL and testbench

//  Parametrised inversionless Berlekamp-Massey key-equation solver for the RS decoder, GF(2^M), correcting up to T symbols.

---
 rtl/rs_gf_pkg.sv | 32 +++
 rtl/rs_gf_mul_vec.sv | 24 ++
 rtl/rs_bm_solver.sv | 157 +++++++++++++++
 tb/tb_rs_bm_solver.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_gf_pkg.sv
// Shared GF(2^M) arithmetic and state encoding for the RS key-equation solver.
// gf_mul reduces a carry-less product by the field polynomial of the caller's width.
package rs_gf_pkg;

  typedef enum logic [1:0] {IDLE, ITER, OUT} state_t;

  localparam int GF_MAXW = 16;

  function automatic logic [GF_MAXW-1:0] gf_mul(
    input logic [GF_MAXW-1:0] a,
    input logic [GF_MAXW-1:0] b,
    input int                 m,
    input logic [GF_MAXW:0]   poly
  );
    logic [GF_MAXW:0]   aa;
    logic [GF_MAXW-1:0] bs;
    logic [GF_MAXW-1:0] p;
    aa = {1'b0, a};
    bs = b;
    p  = '0;
    for (int i = 0; i < GF_MAXW; i++) begin
      if (i < m) begin
        if (bs[0]) p = p ^ aa[GF_MAXW-1:0];
        bs = bs >> 1;
        aa = aa << 1;
        if ((aa & ((GF_MAXW+1)'(1) << m)) != '0) aa = aa ^ poly;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rs_gf_mul_vec.sv
// Dot product of T+1 coefficient pairs over GF(2^M).
// Serves both the BM discrepancy and the omega coefficients.
module rs_gf_mul_vec
  import rs_gf_pkg::*;
#(
  parameter int         M         = 8,
  parameter int         T         = 3,
  parameter logic [M:0] PRIM_POLY = 9'h187
) (
  input  logic [(T+1)*M-1:0] a,
  input  logic [(T+1)*M-1:0] b,
  output logic [M-1:0]       y
);

  always_comb begin
    y = '0;
    for (int j = 0; j <= T; j++) begin
      y = y ^ M'(gf_mul(GF_MAXW'(a[j*M +: M]),
                        GF_MAXW'(b[j*M +: M]),
                        M, (GF_MAXW+1)'(PRIM_POLY)));
    end
  end

endmodule

// File: rtl/rs_bm_solver.sv
// Inversionless Berlekamp-Massey solver: 2T syndromes in, lambda/omega
// streamed one coefficient pair per beat with degree and fail flag.
module rs_bm_solver
  import rs_gf_pkg::*;
#(
  parameter int         M         = 8,
  parameter int         T         = 3,
  parameter logic [M:0] PRIM_POLY = 9'h187
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       syn_valid,
  output logic                       syn_ready,
  input  logic [2*T*M-1:0]           syn_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(T+1)-1:0]     out_idx,
  output logic [M-1:0]               out_lambda,
  output logic [M-1:0]               out_omega,
  output logic                       out_last,
  output logic [$clog2(2*T+1)-1:0]   out_deg,
  output logic                       out_fail
);

  localparam int CW = $clog2(2*T+1);
  localparam int IW = $clog2(T+1);
  localparam int LW = (T+2)*M;
  localparam int BW = (T+1)*M;

  state_t            state;
  logic [2*T*M-1:0]  syn;
  logic [LW-1:0]     lam;
  logic [LW-1:0]     lam_n;
  logic [BW-1:0]     bb;
  logic [BW-1:0]     bb_n;
  logic [M-1:0]      gamma;
  logic [M-1:0]      gamma_n;
  logic [CW-1:0]     len;
  logic [CW-1:0]     len_n;
  logic [CW-1:0]     r;
  logic [BW-1:0]     win;
  logic [M-1:0]      vec_y;
  logic [M-1:0]      delta;
  logic              upd;
  int                k;

  function automatic logic [M-1:0] mul(
    input logic [M-1:0] a,
    input logic [M-1:0] b
  );
    return M'(gf_mul(GF_MAXW'(a), GF_MAXW'(b), M,
                     (GF_MAXW+1)'(PRIM_POLY)));
  endfunction

  // syndrome window S_{k+1-j}: k is r while iterating, idx while streaming
  always_comb begin
    k   = (state == OUT) ? int'(out_idx) : int'(r);
    win = '0;
    for (int j = 0; j <= T; j++) begin
      if (j <= k) win[j*M +: M] = syn[(k-j)*M +: M];
    end
  end

  rs_gf_mul_vec #(
    .M         (M),
    .T         (T),
    .PRIM_POLY (PRIM_POLY)
  ) u_vec (
    .a (lam[BW-1:0]),
    .b (win),
    .y (vec_y)
  );

  assign delta = vec_y;
  assign upd   = (delta != '0) && ({len, 1'b0} <= {1'b0, r});

  always_comb begin
    lam_n = '0;
    lam_n[M-1:0] = mul(gamma, lam[M-1:0]);
    for (int j = 1; j <= T+1; j++) begin
      lam_n[j*M +: M] = mul(gamma, lam[j*M +: M])
                      ^ mul(delta, bb[(j-1)*M +: M]);
    end
  end

  assign bb_n    = upd ? lam[BW-1:0] : {bb[T*M-1:0], {M{1'b0}}};
  assign gamma_n = upd ? delta : gamma;
  assign len_n   = upd ? (r + CW'(1) - len) : len;

  assign out_lambda = lam[out_idx*M +: M];
  assign out_omega  = (state == OUT && out_idx != IW'(T)) ? vec_y : '0;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      syn       <= '0;
      lam       <= '0;
      bb        <= '0;
      gamma     <= '0;
      len       <= '0;
      r         <= '0;
      syn_ready <= 1'b1;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_deg   <= '0;
      out_fail  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (syn_valid) begin
            syn       <= syn_data;
            lam       <= LW'(1);
            bb        <= BW'(1);
            gamma     <= M'(1);
            len       <= '0;
            r         <= '0;
            syn_ready <= 1'b0;
            state     <= ITER;
          end
        end
        ITER: begin
          lam   <= lam_n;
          bb    <= bb_n;
          gamma <= gamma_n;
          len   <= len_n;
          if (r == CW'(2*T-1)) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_deg   <= len_n;
            out_fail  <= len_n > CW'(T);
          end else begin
            r <= r + CW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= '0;
              syn_ready <= 1'b1;
            end else begin
              out_idx  <= out_idx + IW'(1);
              out_last <= (out_idx == IW'(T-1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_bm_solver.sv
// Randomised bench for rs_bm_solver against a log-table GF model,
// an array BM reference and the known error-locator polynomial.
module tb_rs_bm_solver;

  localparam int M = 8;
  localparam int T = 3;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        syn_valid = 1'b0;
  logic        syn_ready;
  logic [47:0] syn_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_idx;
  logic [7:0]  out_lambda;
  logic [7:0]  out_omega;
  logic        out_last;
  logic [2:0]  out_deg;
  logic        out_fail;

  rs_bm_solver dut (
    .clk        (clk),
    .clrn       (clrn),
    .syn_valid  (syn_valid),
    .syn_ready  (syn_ready),
    .syn_data   (syn_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_lambda (out_lambda),
    .out_omega  (out_omega),
    .out_last   (out_last),
    .out_deg    (out_deg),
    .out_fail   (out_fail)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int gexp [0:509];
  int glog [0:255];
  int s [6];
  int e_lam [4];
  int e_om [4];
  int e_deg;
  int e_fail;
  int g_lam [4];
  int g_om [4];
  int g_deg;
  int g_fail;
  int loc [4];
  int pos [4];
  int npos;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[glog[a] + glog[b]];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference: BM as stated, lambda kept to degree T+1, B to degree T
  task automatic model();
    int lam [5];
    int nl [5];
    int bq [4];
    int g, l, d;
    lam = '{1, 0, 0, 0, 0};
    bq  = '{1, 0, 0, 0};
    g = 1;
    l = 0;
    for (int r = 0; r < 2*T; r++) begin
      d = 0;
      for (int j = 0; j <= ((r < T) ? r : T); j++) d ^= gmul(lam[j], s[r-j]);
      for (int j = 0; j <= T+1; j++)
        nl[j] = gmul(g, lam[j]) ^ ((j > 0) ? gmul(d, bq[j-1]) : 0);
      if (d != 0 && 2*l <= r) begin
        for (int j = 0; j <= T; j++) bq[j] = lam[j];
        g = d;
        l = r + 1 - l;
      end else begin
        for (int j = T; j > 0; j--) bq[j] = bq[j-1];
        bq[0] = 0;
      end
      lam = nl;
    end
    for (int i = 0; i <= T; i++) begin
      e_lam[i] = lam[i];
      e_om[i]  = 0;
      if (i < T)
        for (int j = 0; j <= i; j++) e_om[i] ^= gmul(lam[j], s[i-j]);
    end
    e_deg  = l;
    e_fail = (l > T) ? 1 : 0;
  endtask

  task automatic make_errors(input int n);
    int p, ev, dup;
    npos = n;
    loc  = '{1, 0, 0, 0};
    for (int k = 0; k < 6; k++) s[k] = 0;
    for (int e = 0; e < n; e++) begin
      do begin
        p = $urandom_range(254);
        dup = 0;
        for (int q = 0; q < e; q++) if (pos[q] == p) dup = 1;
      end while (dup);
      pos[e] = p;
      ev = $urandom_range(255, 1);
      for (int k = 0; k < 6; k++)
        s[k] ^= gmul(ev, gexp[((k+1)*p) % 255]);
      if (n <= T)
        for (int i = T; i > 0; i--) loc[i] ^= gmul(gexp[p], loc[i-1]);
    end
  endtask

  task automatic send();
    int n = 0;
    while (!syn_ready && n < 100) begin
      step();
      n++;
    end
    check("syn_ready_wait", syn_ready, 1);
    for (int k = 0; k < 6; k++) syn_data[k*8 +: 8] = 8'(s[k]);
    syn_valid = 1'b1;
    step();
    syn_valid = 1'b0;
  endtask

  task automatic run_block(input int duty);
    int lat, beat, cyc;
    model();
    out_ready = 1'b0;
    send();
    lat = 1;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    check("latency", lat, 2*T+1);
    beat = 0;
    cyc = 0;
    while (beat <= T && cyc < 300) begin
      check("valid", out_valid, 1);
      check("syn_ready_busy", syn_ready, 0);
      if (out_valid) begin
        check("idx", out_idx, beat);
        check("lambda", out_lambda, e_lam[beat]);
        check("omega", out_omega, e_om[beat]);
        check("last", out_last, (beat == T) ? 1 : 0);
        check("deg", out_deg, e_deg);
        check("fail", out_fail, e_fail);
        g_lam[beat] = out_lambda;
        g_om[beat]  = out_omega;
        g_deg  = out_deg;
        g_fail = out_fail;
      end
      out_ready = ($urandom_range(99) < duty);
      if (out_valid && out_ready) beat++;
      step();
      cyc++;
    end
    out_ready = 1'b0;
    check("beats", beat, T+1);
    check("syn_ready_after", syn_ready, 1);
    check("valid_after", out_valid, 0);
  endtask

  // DUT locator, scaled to lambda_0 = 1, must be prod(1 + X_e x)
  task automatic check_locator();
    int inv, v, xi;
    check("lam0_nz", (g_lam[0] != 0) ? 1 : 0, 1);
    if (g_lam[0] != 0) begin
      inv = gexp[(255 - glog[g_lam[0]]) % 255];
      for (int i = 0; i <= T; i++)
        check("lam_norm", gmul(g_lam[i], inv), loc[i]);
    end
    for (int e = 0; e < npos; e++) begin
      xi = gexp[(255 - pos[e]) % 255];
      v = 0;
      for (int i = T; i >= 0; i--) v = gmul(v, xi) ^ g_lam[i];
      check("chien_root", v, 0);
    end
    check("deg_nerr", g_deg, npos);
    check("fail_corr", g_fail, 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_ready"}, syn_ready, 1);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_idx"}, out_idx, 0);
  endtask

  initial begin
    int x, n;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x;
      gexp[i+255] = x;
      glog[x] = i;
      x = x << 1;
      if ((x & 'h100) != 0) x ^= 'h187;
    end
    glog[0] = 0;

    #1 clrn = 1'b0;
    #1;
    reset_checks("rst");
    check("rst_lambda", out_lambda, 0);
    check("rst_omega", out_omega, 0);
    check("rst_deg", out_deg, 0);
    check("rst_fail", out_fail, 0);
    step();
    clrn = 1'b1;
    step();

    for (int k = 0; k < 6; k++) s[k] = 0;
    npos = 0;
    loc = '{1, 0, 0, 0};
    run_block(100);
    check("t1_lam0", g_lam[0], 1);
    check("t1_lam1", g_lam[1], 0);
    check("t1_om0", g_om[0], 0);
    check("t1_deg", g_deg, 0);

    for (int k = 0; k < 6; k++) s[k] = 1;
    run_block(100);
    check("t2_lam0", g_lam[0], 1);
    check("t2_lam1", g_lam[1], 1);
    check("t2_lam2", g_lam[2], 0);
    check("t2_om0", g_om[0], 1);
    check("t2_om1", g_om[1], 0);
    check("t2_deg", g_deg, 1);
    check("t2_fail", g_fail, 0);

    for (int b = 0; b < 300; b++) begin
      make_errors($urandom_range(3, 1));
      run_block((b % 2 == 0) ? 100 : 30);
      check_locator();
    end

    for (int b = 0; b < 20; b++) begin
      make_errors(4);
      run_block(30);
    end
    for (int b = 0; b < 20; b++) begin
      for (int k = 0; k < 6; k++) s[k] = $urandom_range(255);
      run_block(50);
    end

    s = '{0, 0, 0, 0, 0, 1};
    run_block(30);
    check("t4a_fail", g_fail, 1);
    check("t4a_deg_ge", (g_deg >= 4) ? 1 : 0, 1);
    s = '{0, 0, 0, 1, 0, 0};
    run_block(30);
    check("t4b_fail", g_fail, 1);
    check("t4b_deg_ge", (g_deg >= 4) ? 1 : 0, 1);

    make_errors(2);
    send();
    step();
    step();
    step();
    clrn = 1'b0;
    #1;
    reset_checks("iter_rst");
    #2 clrn = 1'b1;
    step();
    check("iter_rst_idle", syn_ready, 1);
    check("iter_rst_novalid", out_valid, 0);
    make_errors(3);
    run_block(100);
    check_locator();

    make_errors(3);
    send();
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check("out_rst_valid_pre", out_valid, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_rst_idx_pre", out_idx, 1);
    clrn = 1'b0;
    #1;
    reset_checks("out_rst");
    #2 clrn = 1'b1;
    step();
    check("out_rst_idle", syn_ready, 1);
    make_errors(2);
    run_block(30);
    check_locator();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
